// File: rtl/rvfi_retire_monitor.sv
// rtl/rvfi_retire_monitor.sv - RVFI retirement stream checker with trace FIFO
// Optional PC continuity checking: define RVFI_MON_PC_CHECK_EN.
module rvfi_retire_monitor #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             rvfi_valid,
  input  logic [63:0]      rvfi_order,
  input  logic [31:0]      rvfi_insn,
  input  logic             rvfi_trap,
  input  logic             rvfi_halt,
  input  logic             rvfi_intr,
  input  logic [31:0]      rvfi_pc_rdata,
  input  logic [31:0]      rvfi_pc_wdata,
  input  logic [4:0]       rvfi_rd_addr,
  input  logic [31:0]      rvfi_rd_wdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_order,
  output logic [31:0]      out_insn,
  output logic [31:0]      out_pc,
  output logic [4:0]       out_rd_addr,
  output logic [31:0]      out_rd_wdata,
  output logic             out_trap,
  output logic [CNT_W-1:0] retired_cnt,
  output logic             halted,
  output logic             err_order,
  output logic             err_x0,
  output logic             err_pc,
  output logic             err_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = 64 + 32 + 32 + 5 + 32 + 1;

  typedef enum logic {ST_RUN, ST_HALTED} state_t;

  state_t        state_q, state_d;
  logic          accept;

  logic [AW:0]   wr_ptr, rd_ptr;
  logic [PW-1:0] mem [DEPTH];
  logic [PW-1:0] pkt_in;
  logic [PW-1:0] head;
  logic          empty, full, push, pop;
  logic [63:0]   exp_order;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // Next state and accept qualification; HALTED only leaves through reset
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (rvfi_valid) begin
          accept = 1'b1;
          if (rvfi_halt) state_d = ST_HALTED;
        end
      end
      default: state_d = ST_HALTED;
    endcase
  end

  assign halted = (state_q == ST_HALTED);

  // FIFO status: extra pointer bit distinguishes full from empty
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign push      = accept && (!full || pop);
  assign pkt_in    = {rvfi_order, rvfi_insn, rvfi_pc_rdata, rvfi_rd_addr, rvfi_rd_wdata, rvfi_trap};

  // Pointer update; a pop frees a slot for a same-cycle push when full
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Packet storage; data appears on the output only after the write edge
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= pkt_in;
  end

  // Output fields read zero while nothing is queued
  assign head = out_valid ? mem[rd_ptr[AW-1:0]] : '0;
  assign {out_order, out_insn, out_pc, out_rd_addr, out_rd_wdata, out_trap} = head;

  // Retire counter, order tracking and sticky integrity flags
  always_ff @(posedge clock) begin
    if (reset) begin
      retired_cnt  <= '0;
      exp_order    <= '0;
      err_order    <= 1'b0;
      err_x0       <= 1'b0;
      err_overflow <= 1'b0;
    end else if (accept) begin
      retired_cnt <= retired_cnt + 1'b1;
      exp_order   <= rvfi_order + 64'd1;
      if (rvfi_order != exp_order) err_order <= 1'b1;
      if (rvfi_rd_addr == 5'd0 && rvfi_rd_wdata != 32'd0) err_x0 <= 1'b1;
      if (full && !pop) err_overflow <= 1'b1;
    end
  end

`ifdef RVFI_MON_PC_CHECK_EN
  logic [31:0] last_pc_wdata;
  logic        pc_valid;
  logic        err_pc_q;

  // PC continuity: each instruction must start where the previous one pointed,
  // except the first instruction of a trap handler
  always_ff @(posedge clock) begin
    if (reset) begin
      last_pc_wdata <= '0;
      pc_valid      <= 1'b0;
      err_pc_q      <= 1'b0;
    end else if (accept) begin
      if (pc_valid && !rvfi_intr && (rvfi_pc_rdata != last_pc_wdata)) err_pc_q <= 1'b1;
      last_pc_wdata <= rvfi_pc_wdata;
      pc_valid      <= 1'b1;
    end
  end

  assign err_pc = err_pc_q;
`else
  logic unused_pc_inputs;
  assign unused_pc_inputs = ^{rvfi_pc_wdata, rvfi_intr};
  assign err_pc = 1'b0;
`endif

endmodule

// File: tb/tb_rvfi_retire_monitor.sv
// tb/tb_rvfi_retire_monitor.sv - scoreboard bench for rvfi_retire_monitor
module tb_rvfi_retire_monitor;

  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        rvfi_valid;
  logic [63:0] rvfi_order;
  logic [31:0] rvfi_insn;
  logic        rvfi_trap;
  logic        rvfi_halt;
  logic        rvfi_intr;
  logic [31:0] rvfi_pc_rdata;
  logic [31:0] rvfi_pc_wdata;
  logic [4:0]  rvfi_rd_addr;
  logic [31:0] rvfi_rd_wdata;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_order;
  logic [31:0] out_insn;
  logic [31:0] out_pc;
  logic [4:0]  out_rd_addr;
  logic [31:0] out_rd_wdata;
  logic        out_trap;
  logic [31:0] retired_cnt;
  logic        halted;
  logic        err_order;
  logic        err_x0;
  logic        err_pc;
  logic        err_overflow;

  rvfi_retire_monitor #(.DEPTH(DEPTH), .CNT_W(32)) dut (
    .clock(clock), .reset(reset),
    .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
    .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt), .rvfi_intr(rvfi_intr),
    .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
    .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_order(out_order),
    .out_insn(out_insn), .out_pc(out_pc), .out_rd_addr(out_rd_addr),
    .out_rd_wdata(out_rd_wdata), .out_trap(out_trap),
    .retired_cnt(retired_cnt), .halted(halted), .err_order(err_order),
    .err_x0(err_x0), .err_pc(err_pc), .err_overflow(err_overflow)
  );

  always #5 clock = ~clock;

`ifdef RVFI_MON_PC_CHECK_EN
  localparam bit PC_CHECK = 1'b1;
`else
  localparam bit PC_CHECK = 1'b0;
`endif

  typedef struct {
    logic [63:0] order;
    logic [31:0] insn;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        trap;
  } pkt_t;

  pkt_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  bit          started = 0;

  // Reference model state (what the monitor should hold after each edge)
  int          m_cnt;
  logic [63:0] m_exp;
  logic [31:0] m_retired;
  logic [31:0] m_last_pc;
  bit          m_pc_valid, m_halted, m_eo, m_ex, m_ep, m_ov;
  logic [31:0] g_pc;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_cnt = 0; m_exp = 0; m_retired = 0; m_last_pc = 0;
    m_pc_valid = 0; m_halted = 0; m_eo = 0; m_ex = 0; m_ep = 0; m_ov = 0;
  endtask

  // Apply the effect of the inputs seen at the last edge
  task automatic model_step();
    pkt_t p;
    bit   pop;
    pop = (m_cnt > 0) && out_ready;
    if (!m_halted && rvfi_valid) begin
      m_retired++;
      if (rvfi_order != m_exp) m_eo = 1;
      m_exp = rvfi_order + 1;
      if (rvfi_rd_addr == 0 && rvfi_rd_wdata != 0) m_ex = 1;
      if (PC_CHECK && m_pc_valid && !rvfi_intr && rvfi_pc_rdata != m_last_pc) m_ep = 1;
      m_last_pc  = rvfi_pc_wdata;
      m_pc_valid = 1;
      if (m_cnt < DEPTH || pop) begin
        p.order = rvfi_order; p.insn = rvfi_insn; p.pc = rvfi_pc_rdata;
        p.rd = rvfi_rd_addr; p.wd = rvfi_rd_wdata; p.trap = rvfi_trap;
        exp_q.push_back(p);
        m_cnt++;
      end else begin
        m_ov = 1;
      end
      if (rvfi_halt) m_halted = 1;
    end
    if (pop) m_cnt--;
  endtask

  task automatic cycle(input logic v, input logic [63:0] ord, input logic [4:0] rd,
                       input logic [31:0] wd, input logic h, input logic intr,
                       input logic [31:0] pcr, input logic [31:0] pcw, input logic rdy);
    rvfi_valid = v; rvfi_order = ord; rvfi_rd_addr = rd; rvfi_rd_wdata = wd;
    rvfi_halt = h; rvfi_intr = intr; rvfi_pc_rdata = pcr; rvfi_pc_wdata = pcw;
    rvfi_insn = $urandom; rvfi_trap = $urandom_range(0, 1); out_ready = rdy;
    @(posedge clock);
    #1;
    model_step();
  endtask

  // Continuous-PC retirement with a nonzero destination register
  task automatic retire(input logic [63:0] ord, input logic rdy);
    cycle(1, ord, 5'($urandom_range(1, 31)), $urandom, 0, 0, g_pc, g_pc + 4, rdy);
    g_pc = g_pc + 4;
  endtask

  task automatic idle(input logic rdy);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, rdy);
  endtask

  task automatic do_reset();
    reset = 1; rvfi_valid = 0; out_ready = 0;
    @(posedge clock);
    #1;
    model_clear();
    reset = 0;
    g_pc = 32'h8000_0000;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", {out_order, out_insn, out_pc, out_rd_addr, out_rd_wdata, out_trap}, 0);
    chk("rst_cnt", retired_cnt, 0);
    chk("rst_flags", {halted, err_order, err_x0, err_pc, err_overflow}, 0);
  endtask

  task automatic drain();
    int n = 0;
    while (m_cnt > 0 && n < 64) begin
      idle(1);
      n++;
    end
    chk("drain_done", exp_q.size(), 0);
  endtask

  // Monitor: compare DUT state to the model and pop the scoreboard on handshakes
  always @(negedge clock) begin
    if (started && !reset) begin
      chk("out_valid", out_valid, m_cnt > 0);
      chk("flags", {halted, err_order, err_x0, err_pc, err_overflow}, {m_halted, m_eo, m_ex, m_ep, m_ov});
      chk("retired_cnt", retired_cnt, m_retired);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pkt", 1, 0);
        end else begin
          pkt_t e;
          e = exp_q.pop_front();
          chk("pkt_order", out_order, e.order);
          chk("pkt_body", {out_insn, out_pc, out_rd_addr, out_rd_wdata, out_trap},
              {e.insn, e.pc, e.rd, e.wd, e.trap});
        end
      end
    end
  end

  initial begin
    logic [63:0] g_order;
    logic [4:0]  rd;
    logic [31:0] wd, pcr, pcw;
    logic        v, intr;

    reset = 1; rvfi_valid = 0; rvfi_order = 0; rvfi_insn = 0; rvfi_trap = 0;
    rvfi_halt = 0; rvfi_intr = 0; rvfi_pc_rdata = 0; rvfi_pc_wdata = 0;
    rvfi_rd_addr = 0; rvfi_rd_wdata = 0; out_ready = 0;
    model_clear();
    repeat (2) @(posedge clock);
    do_reset();
    started = 1;

    // In-order stream with a ready sink
    for (int i = 0; i < 6; i++) retire(i, 1);
    drain();
    chk("a_cnt", retired_cnt, 6);
    chk("a_errs", {err_order, err_x0, err_pc, err_overflow}, 0);

    // Order gap: 0,1,3 then 4
    do_reset();
    retire(0, 1); retire(1, 1); retire(3, 1);
    chk("gap_err_order", err_order, 1);
    retire(4, 1);
    chk("gap_sticky", err_order, 1);
    drain();

    // Overflow with a stalled sink
    do_reset();
    for (int i = 0; i < 10; i++) retire(i, 0);
    chk("ovf_flag", err_overflow, 1);
    chk("ovf_cnt", retired_cnt, 10);
    chk("ovf_stored", m_cnt, 8);
    drain();

    // Full FIFO with a coinciding pop accepts the push
    do_reset();
    for (int i = 0; i < 8; i++) retire(i, 0);
    retire(8, 1);
    chk("full_pop_no_ovf", err_overflow, 0);
    drain();

    // x0 write, then halt freezes the monitor
    do_reset();
    cycle(1, 0, 0, 32'h5, 0, 0, g_pc, g_pc + 4, 1); g_pc += 4;
    chk("x0_err", err_x0, 1);
    cycle(1, 1, 5'd3, 32'h1, 1, 0, g_pc, g_pc + 4, 1); g_pc += 4;
    for (int i = 2; i < 5; i++) retire(i, 1);
    chk("halt_state", halted, 1);
    chk("halt_cnt", retired_cnt, 2);
    drain();
    do_reset();

    // PC discontinuity outside and inside a trap handler entry
    cycle(1, 0, 5'd1, 0, 0, 0, 32'h8000_0000, 32'h8000_0004, 1);
    cycle(1, 1, 5'd1, 0, 0, 0, 32'h8000_0010, 32'h8000_0014, 1);
    chk("pc_jump", err_pc, PC_CHECK);
    do_reset();
    cycle(1, 0, 5'd1, 0, 0, 0, 32'h8000_0000, 32'h8000_0004, 1);
    cycle(1, 1, 5'd1, 0, 0, 1, 32'h8000_0010, 32'h8000_0014, 1);
    chk("pc_intr", err_pc, 0);
    drain();

    // Randomized traffic
    do_reset();
    g_order = 0;
    for (int i = 0; i < 3000; i++) begin
      if (m_halted && $urandom_range(0, 7) == 0) begin
        do_reset();
        g_order = 0;
      end else begin
        v    = ($urandom_range(0, 9) < 7);
        rd   = 5'($urandom_range(0, 31));
        wd   = (rd == 0 && $urandom_range(0, 9) != 0) ? 32'd0 : $urandom;
        intr = ($urandom_range(0, 19) == 0);
        pcr  = ($urandom_range(0, 29) == 0) ? $urandom : g_pc;
        pcw  = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(0, 39) == 0) g_order = g_order + $urandom_range(2, 5);
        cycle(v, g_order, rd, wd, ($urandom_range(0, 299) == 0), intr, pcr, pcw,
              ($urandom_range(0, 9) < 6));
        if (v) begin
          g_order = g_order + 1;
          g_pc = pcw;
        end
      end
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rvfi_retire_monitor.md
Name: rvfi_retire_monitor

Overview:
- Receives the single-channel RVFI retirement stream that the core wrapper drives from el2_veer during formal and simulation runs.
- Checks stream integrity: order sequencing, x0 writes and PC continuity.
- Buffers retired-instruction packets in a FIFO and drains them over a valid/ready port to a trace sink or scoreboard.
- Maintains sticky error flags, a retired-instruction counter and halt state.

Parameters:
DEPTH, 8, FIFO entries; power of two, at least 2.
CNT_W, 32, width of retired-instruction counter.

Ports:
clock  input  1  sole clock, rising edge.
reset  input  1  synchronous, active-high reset.
rvfi_valid  input  1  retirement strobe.
rvfi_order  input  64  instruction index.
rvfi_insn  input  32  instruction word.
rvfi_trap  input  1  retired instruction trapped.
rvfi_halt  input  1  last instruction before halt.
rvfi_intr  input  1  first instruction of trap handler.
rvfi_pc_rdata  input  32  PC of instruction.
rvfi_pc_wdata  input  32  next PC.
rvfi_rd_addr  input  5  destination register.
rvfi_rd_wdata  input  32  destination write data.
out_valid  output  1  packet available.
out_ready  input  1  sink accepts packet.
out_order  output  64  packet order.
out_insn  output  32  packet instruction.
out_pc  output  32  packet pc_rdata.
out_rd_addr  output  5  packet rd_addr.
out_rd_wdata  output  32  packet rd_wdata.
out_trap  output  1  packet trap.
retired_cnt  output  CNT_W  accepted retirements.
halted  output  1  monitor in HALTED.
err_order  output  1  sticky order mismatch.
err_x0  output  1  sticky x0 nonzero write.
err_pc  output  1  sticky PC discontinuity.
err_overflow  output  1  sticky FIFO overflow.

Behaviour:
- Reset: all outputs 0. FIFO empty, expected order = 0, pc_valid = 0, state = RUN.
- FSM states: RUN and HALTED.
  - RUN -> HALTED on an accepted rvfi_valid with rvfi_halt = 1.
  - HALTED is exited only by reset.
  - halted = (state == HALTED).
  - In HALTED, rvfi_valid is ignored: no push, no checks, no count. The FIFO continues to drain.
- Accept: rvfi_valid in RUN.
- On accept:
  - retired_cnt increments, wrapping at 2^CNT_W.
  - If rvfi_order != expected order, set err_order. Expected order then becomes rvfi_order + 1, i.e. it resynchronises to the observed value.
  - If rvfi_rd_addr == 0 and rvfi_rd_wdata != 0, set err_x0.
- Push:
  - Accept with FIFO not full: push the packet; write data is visible on out_* no earlier than the next cycle (1-cycle latency, registered storage).
  - Accept with FIFO full and no simultaneous pop: packet dropped, err_overflow set.
  - Full with a simultaneous pop: push succeeds, no overflow.
- Pop: out_valid = FIFO non-empty. Pop on out_valid & out_ready. out_* hold stable while out_valid & !out_ready.
- Empty FIFO with simultaneous push and pop: no bypass. out_valid rises the cycle after the push.
- Pointers: log2(DEPTH)+1 bits, wrap naturally. full/empty are derived from the MSB compare.
- Error flags are sticky until reset and may coexist.
- Reset mid-operation: FIFO flushed, counters and errors cleared, packets in flight lost, state returns to RUN.

Optional Feature:
RVFI_MON_PC_CHECK_EN
- Defined:
  - Monitor keeps last_pc_wdata and pc_valid.
  - On accept with pc_valid = 1, rvfi_intr = 0 and rvfi_pc_rdata != last_pc_wdata, set err_pc.
  - Every accept updates last_pc_wdata and sets pc_valid = 1.
  - Reset clears pc_valid.
- Undefined: no PC state is instantiated and err_pc is tied to 0.

Test Plan:
- Orders 0..5 retired on consecutive cycles, out_ready = 1 -> six packets out in order 0..5 starting one cycle after first accept. retired_cnt = 6, all err_* = 0.
- Orders 0, 1, 3 -> err_order set at the order-3 accept. A following order 4 raises no new mismatch, and err_order stays 1.
- DEPTH = 8, out_ready = 0, 10 retirements -> 8 stored, err_overflow = 1, retired_cnt = 10. Drain -> orders 0..7 out.
- FIFO full, a retirement coinciding with out_ready = 1 -> no overflow, 9th packet delivered after the first 8.
- Retire rd_addr = 0, rd_wdata = 0x5 -> err_x0 = 1. Retire with rvfi_halt = 1, then further rvfi_valid -> halted = 1, retired_cnt frozen. Reset -> all outputs 0, state RUN.
- With RVFI_MON_PC_CHECK_EN defined:
  - pc_wdata = 0x80000004 followed by pc_rdata = 0x80000010, intr = 0 -> err_pc = 1.
  - The same sequence with intr = 1 -> err_pc = 0.
  - Without the macro -> err_pc = 0 in both cases.
